regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clr_fsm.sv | 63 ++++++
 rtl/regfile_param.sv | 98 +++++++++
 tb/tb_regfile_param.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parameterised register file.
package regfile_pkg;

    localparam int unsigned DEF_XLEN  = 32;
    localparam int unsigned DEF_NREGS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear-walk controller: steps a pointer over registers 1..NREGS-1 so the
// storage can be zeroed one entry per cycle; reset starts a fresh walk.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter  int unsigned NREGS = DEF_NREGS,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic [AW-1:0] ptr
);

    localparam logic [AW-1:0] PTR_FIRST = AW'(1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(NREGS - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    // Reset lands in CLEAR so the reset-less storage gets zeroed by the walk.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= PTR_FIRST;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = PTR_FIRST;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == PTR_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign clr_busy = (state_q == CLEAR);
    assign clr_done = (state_q == DONE);
    assign ptr      = ptr_q;

endmodule

// File: rtl/regfile_param.sv
// Parameterised 1W/2R register file with r0 hard-wired to zero and a
// cycle-per-entry clear walk. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN  = DEF_XLEN,
    parameter  int unsigned NREGS = DEF_NREGS,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done,
    output logic            wr_drop,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [AW-1:0]   clr_ptr;
    logic            wr_en;
    logic            wr_drop_q, wr_drop_d;
    logic [XLEN-1:0] dbg_data_q, dbg_data_d;

    regfile_clr_fsm #(
        .NREGS (NREGS)
    ) u_clr_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .ptr      (clr_ptr)
    );

    assign wr_en = we && (waddr != '0);

    // Storage has no reset so it can map onto RAM; the walk owns the port while busy.
    always_ff @(posedge clk) begin
        if (clr_busy) begin
            mem_q[clr_ptr] <= '0;
        end else if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = mem_q[raddr1];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end
`endif
        if (clr_busy || (raddr1 == '0)) begin
            rdata1 = '0;
        end
    end

    always_comb begin
        rdata2 = mem_q[raddr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end
`endif
        if (clr_busy || (raddr2 == '0)) begin
            rdata2 = '0;
        end
    end

    // Debug port shows raw storage, including mid-walk contents.
    always_comb begin
        wr_drop_d  = wr_en && clr_busy;
        dbg_data_d = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_drop_q  <= 1'b0;
            dbg_data_q <= '0;
        end else begin
            wr_drop_q  <= wr_drop_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    assign wr_drop  = wr_drop_q;
    assign dbg_data = dbg_data_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios plus randomized
// traffic against a behavioural model of the register file and clear walk.
module tb_regfile_param;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned XLEN2  = 16;
    localparam int unsigned NREGS2 = 8;
    localparam int unsigned AW2    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, we, clr_req;
    logic [AW-1:0]   waddr, raddr1, raddr2, dbg_addr;
    logic [XLEN-1:0] wdata, rdata1, rdata2, dbg_data;
    logic            clr_busy, clr_done, wr_drop;

    logic             s_we, s_clr_req;
    logic [AW2-1:0]   s_waddr, s_raddr1, s_raddr2, s_dbg_addr;
    logic [XLEN2-1:0] s_wdata, s_rdata1, s_rdata2, s_dbg_data;
    logic             s_busy, s_done, s_drop;

    int checks = 0;
    int errors = 0;

    regfile_param #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
        .wr_drop(wr_drop), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    regfile_param #(.XLEN(XLEN2), .NREGS(NREGS2)) dut_small (
        .clk(clk), .reset(reset), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
        .raddr1(s_raddr1), .raddr2(s_raddr2), .rdata1(s_rdata1), .rdata2(s_rdata2),
        .clr_req(s_clr_req), .clr_busy(s_busy), .clr_done(s_done),
        .wr_drop(s_drop), .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data)
    );

    // Reference model: register contents plus "busy cycles left" for the walk.
    logic [XLEN-1:0] m_reg [NREGS];
    bit              m_val [NREGS];
    int              m_busy_left = 0;
    bit              m_done = 1'b0;
    bit              m_drop = 1'b0;
    logic [XLEN-1:0] m_dbg = '0;
    bit              m_dbg_val = 1'b0;

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        if (m_busy_left > 0 || a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && waddr != '0 && waddr == a) return wdata;
`endif
        return m_reg[a];
    endfunction

    function automatic void model_edge();
        int k;
        m_dbg_val = (dbg_addr == '0) || m_val[dbg_addr];
        m_dbg     = (dbg_addr == '0) ? '0 : m_reg[dbg_addr];
        if (reset) begin
            m_busy_left = int'(NREGS) - 1;
            m_done = 1'b0; m_drop = 1'b0; m_dbg = '0; m_dbg_val = 1'b1;
        end else if (m_busy_left > 0) begin
            m_drop = we && (waddr != '0);
            k = int'(NREGS) - m_busy_left;
            m_reg[k] = '0; m_val[k] = 1'b1;
            m_busy_left--;
            m_done = (m_busy_left == 0);
        end else begin
            m_drop = 1'b0;
            if (we && waddr != '0) begin
                m_reg[waddr] = wdata; m_val[waddr] = 1'b1;
            end
            if (clr_req && !m_done) m_busy_left = int'(NREGS) - 1;
            m_done = 1'b0;
        end
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int busy_n = 0, done_n = 0, done_at = 0, s_busy_n = 0, s_done_at = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b1 || clr_done !== 1'b0 || wr_drop !== 1'b0 || dbg_data !== '0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b drop=%b dbg=%h expected 1 0 0 0",
                     clr_busy, clr_done, wr_drop, dbg_data);
        end
        for (int c = 1; c <= 40; c++) begin
            if (clr_busy) busy_n++;
            if (clr_done) begin done_n++; if (done_at == 0) done_at = c; end
            if (s_busy) s_busy_n++;
            if (s_done && s_done_at == 0) s_done_at = c;
            step();
        end
        checks++;
        if (busy_n != 31 || done_at != 32 || done_n != 1) begin
            errors++;
            $display("FAIL reset_walk busy=%0d done_at=%0d done_n=%0d expected 31 32 1", busy_n, done_at, done_n);
        end
        checks++;
        if (s_busy_n != 7 || s_done_at != 8) begin
            errors++;
            $display("FAIL small_walk busy=%0d done_at=%0d expected 7 8", s_busy_n, s_done_at);
        end
        checks++;
        if (s_drop !== 1'b0 || s_dbg_data !== '0) begin
            errors++;
            $display("FAIL small_idle drop=%b dbg=%h expected 0 0", s_drop, s_dbg_data);
        end
        for (int a = 0; a < int'(NREGS); a++) begin
            raddr1 = AW'(a); raddr2 = AW'(31 - a);
            s_raddr1 = AW2'(a % 8); s_raddr2 = AW2'(7 - (a % 8));
            #1;
            checks++;
            if (rdata1 !== '0 || rdata2 !== '0 || s_rdata1 !== '0 || s_rdata2 !== '0) begin
                errors++;
                $display("FAIL reset_zero a=%0d got %h %h %h %h expected 0", a, rdata1, rdata2, s_rdata1, s_rdata2);
            end
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        we = 1'b0; raddr1 = 5'd5;
        #1;
        checks++;
        if (rdata1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL write_r5 got %h expected deadbeef", rdata1);
        end
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
        step();
        we = 1'b0; raddr2 = 5'd0;
        #1;
        checks++;
        if (rdata2 !== '0 || wr_drop !== 1'b0 || rdata1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_r0 rd2=%h drop=%b rd1=%h expected 0 0 deadbeef", rdata2, wr_drop, rdata1);
        end
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] exp;
        we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        step();
        wdata = 32'hA5A5A5A5; raddr1 = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp = 32'hA5A5A5A5;
`else
        exp = 32'h11111111;
`endif
        checks++;
        if (rdata1 !== exp) begin
            errors++; $display("FAIL bypass_same_cycle got %h expected %h", rdata1, exp);
        end
        step();
        we = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL bypass_next_cycle got %h expected a5a5a5a5", rdata1);
        end
    endtask

    task automatic test_debug();
        we = 1'b1; waddr = 5'd9; wdata = 32'h77;
        step();
        we = 1'b0; dbg_addr = 5'd9;
        step();
        checks++;
        if (dbg_data !== 32'h77) begin
            errors++; $display("FAIL debug_r9 got %h expected 77", dbg_data);
        end
        dbg_addr = 5'd0;
        step();
        checks++;
        if (dbg_data !== '0) begin
            errors++; $display("FAIL debug_r0 got %h expected 0", dbg_data);
        end
    endtask

    task automatic test_busy_drop();
        we = 1'b1; waddr = 5'd2; wdata = 32'hBEEF;
        step();
        we = 1'b0; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step();
        checks++;
        if (clr_busy !== 1'b1) begin
            errors++; $display("FAIL drop_busy got %b expected 1", clr_busy);
        end
        we = 1'b1; waddr = 5'd3; wdata = 32'h55;
        step();
        we = 1'b0;
        checks++;
        if (wr_drop !== 1'b1) begin
            errors++; $display("FAIL drop_r3 got %b expected 1", wr_drop);
        end
        we = 1'b1; waddr = 5'd2; wdata = 32'h99;
        step();
        we = 1'b0;
        checks++;
        if (wr_drop !== 1'b1) begin
            errors++; $display("FAIL drop_r2 got %b expected 1", wr_drop);
        end
        step();
        checks++;
        if (wr_drop !== 1'b0) begin
            errors++; $display("FAIL drop_pulse got %b expected 0", wr_drop);
        end
        for (int c = 0; c < 40 && !clr_done; c++) step();
        checks++;
        if (clr_done !== 1'b1) begin
            errors++; $display("FAIL drop_done_timeout got %b expected 1", clr_done);
        end
        step();
        raddr1 = 5'd3; raddr2 = 5'd2;
        #1;
        checks++;
        if (rdata1 !== '0 || rdata2 !== '0) begin
            errors++; $display("FAIL drop_cleared r3=%h r2=%h expected 0 0", rdata1, rdata2);
        end
    endtask

    task automatic test_back_to_back();
        we = 1'b1; waddr = 5'd30; wdata = 32'hCAFE0001; clr_req = 1'b1; dbg_addr = 5'd30;
        step();
        we = 1'b0; clr_req = 1'b0;
        step();
        checks++;
        if (dbg_data !== 32'hCAFE0001 || clr_busy !== 1'b1) begin
            errors++; $display("FAIL b2b_write_landed dbg=%h busy=%b expected cafe0001 1", dbg_data, clr_busy);
        end
        for (int c = 0; c < 40 && !clr_done; c++) step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        checks++;
        if (clr_busy !== 1'b0) begin
            errors++; $display("FAIL b2b_req_in_done busy=%b expected 0", clr_busy);
        end
        raddr1 = 5'd30;
        #1;
        checks++;
        if (rdata1 !== '0) begin
            errors++; $display("FAIL b2b_cleared got %h expected 0", rdata1);
        end
    endtask

    task automatic test_reset_midwalk();
        int busy_n = 0, done_n = 0, done_at = 0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (clr_busy) busy_n++;
            if (clr_done) begin done_n++; if (done_at == 0) done_at = c; end
            step();
        end
        checks++;
        if (done_at != 32 || done_n != 1 || busy_n != 31) begin
            errors++;
            $display("FAIL midwalk_reset done_at=%0d done_n=%0d busy=%0d expected 32 1 31", done_at, done_n, busy_n);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            we       = ($urandom_range(0, 2) != 0);
            waddr    = AW'($urandom_range(0, NREGS - 1));
            wdata    = $urandom();
            raddr1   = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, NREGS - 1));
            raddr2   = AW'($urandom_range(0, NREGS - 1));
            dbg_addr = AW'($urandom_range(0, NREGS - 1));
            clr_req  = ($urandom_range(0, 59) == 0);
            #1;
            checks++;
            if (rdata1 !== exp_rd(raddr1) || rdata2 !== exp_rd(raddr2)) begin
                errors++;
                $display("FAIL rand_read i=%0d got %h %h expected %h %h", i, rdata1, rdata2,
                         exp_rd(raddr1), exp_rd(raddr2));
            end
            checks++;
            if (clr_busy !== (m_busy_left > 0) || clr_done !== m_done || wr_drop !== m_drop) begin
                errors++;
                $display("FAIL rand_ctrl i=%0d busy=%b done=%b drop=%b expected %b %b %b", i,
                         clr_busy, clr_done, wr_drop, (m_busy_left > 0), m_done, m_drop);
            end
            if (m_dbg_val) begin
                checks++;
                if (dbg_data !== m_dbg) begin
                    errors++; $display("FAIL rand_dbg i=%0d got %h expected %h", i, dbg_data, m_dbg);
                end
            end
            step();
        end
        we = 1'b0; clr_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < int'(NREGS); i++) begin
            m_reg[i] = '0; m_val[i] = (i == 0);
        end
        reset = 1'b1; we = 1'b0; clr_req = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; dbg_addr = '0;
        s_we = 1'b0; s_clr_req = 1'b0; s_waddr = '0; s_wdata = '0;
        s_raddr1 = '0; s_raddr2 = '0; s_dbg_addr = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_debug();
        test_busy_drop();
        test_back_to_back();
        test_reset_midwalk();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
